// File: rtl/conv_layer_sched.sv
// conv_layer_sched: layer sequencer for a convolution engine.
//
// For every output-channel group it streams W_WORDS weight reads and
// B_WORDS bias reads out of the parameter SRAMs. It then sweeps the output
// tile grid in raster order (x fastest), handshaking each tile with the
// conv datapath. After the last group it pulses layer_done.
//
// Optional feature: define CONV_SCHED_PERF_CNT_EN to add the stall_cnt
// output. stall_cnt is a saturating count of sweep cycles in which the
// datapath held off a tile.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle layer launch (sampled in IDLE only)
//   abort                      synchronous cancel of the running layer
//   grid_w, grid_h             tile columns / rows (0 is treated as 1)
//   num_groups                 output-channel groups (0 is treated as 1)
//   w_base, b_base             first weight / bias SRAM address
//   sram_raddr_weight/_bias    SRAM read addresses (held outside issue states)
//   w_load_valid, b_load_valid read data valid (issue strobe + 1 cycle)
//   tile_valid, tile_ready     tile request handshake
//   tile_x, tile_y, group_idx  current tile coordinate and group
//   busy, layer_done           activity flag, one-cycle completion pulse
//   stall_cnt                  (CONV_SCHED_PERF_CNT_EN only) stall counter
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | issuing W_WORDS weight reads for the current group
// LOAD_B | issuing B_WORDS bias reads for the current group
// SWEEP  | presenting tiles to the datapath
// DONE   | layer_done pulse, then back to IDLE
module conv_layer_sched #(
    parameter int W_WORDS = 16,
    parameter int B_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  grid_w,
    input  logic [2:0]  grid_h,
    input  logic [6:0]  num_groups,
    input  logic [10:0] w_base,
    input  logic [6:0]  b_base,
    input  logic        tile_ready,
    output logic [10:0] sram_raddr_weight,
    output logic [6:0]  sram_raddr_bias,
    output logic        w_load_valid,
    output logic        b_load_valid,
    output logic        tile_valid,
    output logic [2:0]  tile_x,
    output logic [2:0]  tile_y,
    output logic [6:0]  group_idx,
    output logic        busy,
    output logic        layer_done
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int WCW = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
    localparam int BCW = (B_WORDS > 1) ? $clog2(B_WORDS) : 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(W_WORDS - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(B_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, SWEEP, DONE} state_t;

    state_t          state;
    logic [2:0]      cfg_w;
    logic [2:0]      cfg_h;
    logic [6:0]      cfg_groups;
    // Pointers hold the NEXT address to issue; the address outputs carry the
    // address issued in the current cycle.
    logic [10:0]     w_ptr;
    logic [6:0]      b_ptr;
    logic [WCW-1:0]  w_cnt;
    logic [BCW-1:0]  b_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cfg_w             <= '0;
            cfg_h             <= '0;
            cfg_groups        <= '0;
            w_ptr             <= '0;
            b_ptr             <= '0;
            w_cnt             <= '0;
            b_cnt             <= '0;
            sram_raddr_weight <= '0;
            sram_raddr_bias   <= '0;
            w_load_valid      <= 1'b0;
            b_load_valid      <= 1'b0;
            tile_valid        <= 1'b0;
            tile_x            <= '0;
            tile_y            <= '0;
            group_idx         <= '0;
            layer_done        <= 1'b0;
        end else begin
            // One-cycle SRAM latency: valid is the issue state delayed.
            w_load_valid <= (state == LOAD_W);
            b_load_valid <= (state == LOAD_B);

            if (abort && (state != IDLE)) begin
                // Abort wins over any handshake; in-flight read data is dropped.
                state        <= IDLE;
                tile_valid   <= 1'b0;
                layer_done   <= 1'b0;
                w_load_valid <= 1'b0;
                b_load_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        layer_done <= 1'b0;
                        if (start) begin
                            cfg_w             <= (grid_w == 3'd0) ? 3'd1 : grid_w;
                            cfg_h             <= (grid_h == 3'd0) ? 3'd1 : grid_h;
                            cfg_groups        <= (num_groups == 7'd0) ? 7'd1 : num_groups;
                            sram_raddr_weight <= w_base;
                            w_ptr             <= w_base + 11'd1;
                            b_ptr             <= b_base;
                            w_cnt             <= W_LAST;
                            group_idx         <= '0;
                            tile_x            <= '0;
                            tile_y            <= '0;
                            state             <= LOAD_W;
                        end
                    end
                    LOAD_W: begin
                        if (w_cnt == '0) begin
                            sram_raddr_bias <= b_ptr;
                            b_ptr           <= b_ptr + 7'd1;
                            b_cnt           <= B_LAST;
                            state           <= LOAD_B;
                        end else begin
                            sram_raddr_weight <= w_ptr;
                            w_ptr             <= w_ptr + 11'd1;
                            w_cnt             <= w_cnt - 1'b1;
                        end
                    end
                    LOAD_B: begin
                        if (b_cnt == '0) begin
                            tile_valid <= 1'b1;
                            tile_x     <= '0;
                            tile_y     <= '0;
                            state      <= SWEEP;
                        end else begin
                            sram_raddr_bias <= b_ptr;
                            b_ptr           <= b_ptr + 7'd1;
                            b_cnt           <= b_cnt - 1'b1;
                        end
                    end
                    SWEEP: begin
                        if (tile_valid && tile_ready) begin
                            if (tile_x == cfg_w - 3'd1) begin
                                tile_x <= '0;
                                if (tile_y == cfg_h - 3'd1) begin
                                    tile_y     <= '0;
                                    tile_valid <= 1'b0;
                                    if (group_idx < cfg_groups - 7'd1) begin
                                        group_idx         <= group_idx + 7'd1;
                                        sram_raddr_weight <= w_ptr;
                                        w_ptr             <= w_ptr + 11'd1;
                                        w_cnt             <= W_LAST;
                                        state             <= LOAD_W;
                                    end else begin
                                        layer_done <= 1'b1;
                                        state      <= DONE;
                                    end
                                end else begin
                                    tile_y <= tile_y + 3'd1;
                                end
                            end else begin
                                tile_x <= tile_x + 3'd1;
                            end
                        end
                    end
                    DONE: begin
                        layer_done <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CONV_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == SWEEP) && tile_valid && !tile_ready &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Testbench for conv_layer_sched: randomized layers checked against a
// queue-based model of the expected weight/bias address streams and tile order.
module tb_conv_layer_sched;
    localparam int W = 16;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  grid_w = '0;
    logic [2:0]  grid_h = '0;
    logic [6:0]  num_groups = '0;
    logic [10:0] w_base = '0;
    logic [6:0]  b_base = '0;
    logic        tile_ready = 1'b0;
    logic [10:0] sram_raddr_weight;
    logic [6:0]  sram_raddr_bias;
    logic        w_load_valid, b_load_valid, tile_valid, busy, layer_done;
    logic [2:0]  tile_x, tile_y;
    logic [6:0]  group_idx;
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_layer_sched #(.W_WORDS(W), .B_WORDS(B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .grid_w(grid_w), .grid_h(grid_h), .num_groups(num_groups),
        .w_base(w_base), .b_base(b_base),
        .sram_raddr_weight(sram_raddr_weight), .sram_raddr_bias(sram_raddr_bias),
        .w_load_valid(w_load_valid), .b_load_valid(b_load_valid),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_x(tile_x), .tile_y(tile_y), .group_idx(group_idx),
        .busy(busy), .layer_done(layer_done)
`ifdef CONV_SCHED_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [35:0] all_out;
    assign all_out = {sram_raddr_weight, sram_raddr_bias, w_load_valid, b_load_valid,
                      tile_valid, tile_x, tile_y, group_idx, busy, layer_done};

    int vectors = 0;
    int errors  = 0;

    // observations captured by run_layer
    int obs_w[$], obs_b[$], obs_t[$], obs_wc[$];
    int done_cnt, hold_viol, overlap_viol;
    bit timed_out, ab_busy, ab_tv, ab_lv;
    // model expectations
    int exp_w[$], exp_b[$], exp_t[$], exp_wc[$];

    function automatic int qdiff(input int a[$], input int b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // Expected streams from the layer rules: each group reads W contiguous
    // weight words and B contiguous bias words (pointers never rewind), then
    // visits every tile in raster order. An abort truncates the tile list.
    task automatic build_expected(input int gw, input int gh, input int ng,
                                  input int wb, input int bb,
                                  input int ab_g, input int ab_x, input int ab_y);
        int w = (gw == 0) ? 1 : gw;
        int h = (gh == 0) ? 1 : gh;
        int g_n = (ng == 0) ? 1 : ng;
        int last_g = (ab_g >= 0) ? ab_g : g_n - 1;
        bit stop = 0;
        exp_w.delete(); exp_b.delete(); exp_t.delete(); exp_wc.delete();
        for (int g = 0; g <= last_g; g++) begin
            for (int i = 0; i < W; i++) exp_w.push_back((wb + g * W + i) % 2048);
            for (int i = 0; i < B; i++) exp_b.push_back((bb + g * B + i) % 128);
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    if (g == ab_g && x == ab_x && y == ab_y) stop = 1;
                    if (!stop) begin
                        exp_t.push_back(g * 64 + y * 8 + x);
                        exp_wc.push_back((g + 1) * W);
                    end
                end
        end
    endtask

    // mode 0: ready always high, 1: ready on every third sweep cycle, 2: random
    task automatic run_layer(input int gw, input int gh, input int ng, input int wb,
                             input int bb, input int mode, input int ab_g,
                             input int ab_x, input int ab_y, input int restart_at);
        int prev_wa, prev_ba, px, py, phase;
        bit prev_wv, prev_bv, prev_stall, rdy, aborted, finished;
        obs_w.delete(); obs_b.delete(); obs_t.delete(); obs_wc.delete();
        done_cnt = 0; hold_viol = 0; overlap_viol = 0;
        ab_busy = 1; ab_tv = 1; ab_lv = 1;
        aborted = 0; finished = 0; phase = 0; prev_stall = 0; px = 0; py = 0;
        @(posedge clk); #1;
        grid_w = 3'(gw); grid_h = 3'(gh); num_groups = 7'(ng);
        w_base = 11'(wb); b_base = 7'(bb); start = 1'b1;
        prev_wa = sram_raddr_weight; prev_ba = sram_raddr_bias;
        prev_wv = w_load_valid; prev_bv = b_load_valid;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (w_load_valid) obs_w.push_back(prev_wa);
            if (b_load_valid) begin
                obs_b.push_back(prev_ba);
                if (!prev_bv && !prev_wv) overlap_viol++;
            end
            if (layer_done) done_cnt++;
            if (prev_stall && tile_valid && (int'(tile_x) != px || int'(tile_y) != py))
                hold_viol++;
            if (aborted) begin
                ab_busy = busy; ab_tv = tile_valid; ab_lv = w_load_valid | b_load_valid;
                finished = 1;
                break;
            end
            if (!busy) begin
                if (layer_done) done_cnt += 100;
                finished = 1;
                break;
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) begin
                if (tile_valid) begin
                    rdy = (phase == 2);
                    phase = rdy ? 0 : phase + 1;
                end else begin
                    phase = 0;
                    rdy = 1'($urandom_range(0, 1));
                end
            end else rdy = 1'($urandom_range(0, 1));
            abort = 1'b0;
            if (ab_g >= 0 && tile_valid && int'(group_idx) == ab_g &&
                int'(tile_x) == ab_x && int'(tile_y) == ab_y) begin
                abort = 1'b1; rdy = 1'b1; aborted = 1;
            end
            start = (c == restart_at);
            grid_w = 3'($urandom); grid_h = 3'($urandom); num_groups = 7'($urandom);
            w_base = 11'($urandom); b_base = 7'($urandom);
            tile_ready = rdy;
            if (tile_valid && tile_ready && !abort) begin
                obs_t.push_back(int'(group_idx) * 64 + int'(tile_y) * 8 + int'(tile_x));
                obs_wc.push_back(obs_w.size());
            end
            prev_stall = tile_valid && !tile_ready;
            px = tile_x; py = tile_y;
            prev_wa = sram_raddr_weight; prev_ba = sram_raddr_bias;
            prev_wv = w_load_valid; prev_bv = b_load_valid;
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0;
        end
        timed_out = !finished;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (all_out !== 36'd0) begin
            errors++; $display("FAIL reset_hold: outputs %h, need 0", all_out);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (all_out !== 36'd0) begin
                errors++; $display("FAIL reset_idle: outputs %h, need 0", all_out);
            end
        end
`ifdef CONV_SCHED_PERF_CNT_EN
        vectors++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_stall: got %0d need 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_full_layer();
        int d;
        build_expected(6, 6, 4, 0, 0, -1, 0, 0);
        run_layer(6, 6, 4, 0, 0, 0, -1, 0, 0, -1);
        vectors++; if (timed_out) begin errors++; $display("FAIL full_timeout: busy never dropped"); end
        d = qdiff(obs_w, exp_w); vectors++;
        if (d != -1) begin errors++; $display("FAIL full_waddr: idx %0d got %0d need %0d", d, qat(obs_w, d), qat(exp_w, d)); end
        d = qdiff(obs_b, exp_b); vectors++;
        if (d != -1) begin errors++; $display("FAIL full_baddr: idx %0d got %0d need %0d", d, qat(obs_b, d), qat(exp_b, d)); end
        d = qdiff(obs_t, exp_t); vectors++;
        if (d != -1) begin errors++; $display("FAIL full_tiles: idx %0d got %0d need %0d", d, qat(obs_t, d), qat(exp_t, d)); end
        d = qdiff(obs_wc, exp_wc); vectors++;
        if (d != -1) begin errors++; $display("FAIL full_order: idx %0d weights seen %0d need %0d", d, qat(obs_wc, d), qat(exp_wc, d)); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done: pulses %0d need 1", done_cnt); end
        vectors++; if (overlap_viol !== 0) begin errors++; $display("FAIL full_overlap: %0d bias starts without weight overlap, need 0", overlap_viol); end
        vectors++; if (sram_raddr_weight !== 11'd63) begin errors++; $display("FAIL full_wlast: got %0d need 63", sram_raddr_weight); end
        vectors++; if (sram_raddr_bias !== 7'd15) begin errors++; $display("FAIL full_blast: got %0d need 15", sram_raddr_bias); end
    endtask

    task automatic test_stall();
        int d;
        int bb = $urandom_range(0, 127);
        int wb = $urandom_range(0, 2047);
        build_expected(5, 5, 1, wb, bb, -1, 0, 0);
        run_layer(5, 5, 1, wb, bb, 1, -1, 0, 0, -1);
        d = qdiff(obs_t, exp_t); vectors++;
        if (d != -1) begin errors++; $display("FAIL stall_tiles: idx %0d got %0d need %0d", d, qat(obs_t, d), qat(exp_t, d)); end
        vectors++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold: %0d coordinate moves while stalled, need 0", hold_viol); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done: pulses %0d need 1", done_cnt); end
`ifdef CONV_SCHED_PERF_CNT_EN
        vectors++; if (stall_cnt !== 16'd50) begin errors++; $display("FAIL stall_cnt: got %0d need 50", stall_cnt); end
`endif
    endtask

    task automatic test_wrap();
        int d;
        int gw = $urandom_range(1, 7);
        build_expected(gw, 2, 2, 2040, 126, -1, 0, 0);
        run_layer(gw, 2, 2, 2040, 126, 2, -1, 0, 0, -1);
        d = qdiff(obs_w, exp_w); vectors++;
        if (d != -1) begin errors++; $display("FAIL wrap_waddr: idx %0d got %0d need %0d", d, qat(obs_w, d), qat(exp_w, d)); end
        d = qdiff(obs_b, exp_b); vectors++;
        if (d != -1) begin errors++; $display("FAIL wrap_baddr: idx %0d got %0d need %0d", d, qat(obs_b, d), qat(exp_b, d)); end
        vectors++; if (sram_raddr_weight !== 11'd23) begin errors++; $display("FAIL wrap_wlast: got %0d need 23", sram_raddr_weight); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done: pulses %0d need 1", done_cnt); end
    endtask

    task automatic test_abort();
        int d;
        build_expected(5, 4, 4, 100, 10, 2, 3, 1);
        run_layer(5, 4, 4, 100, 10, 2, 2, 3, 1, -1);
        vectors++; if (ab_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b need 0", ab_busy); end
        vectors++; if (ab_tv !== 1'b0) begin errors++; $display("FAIL abort_tvalid: got %0b need 0", ab_tv); end
        vectors++; if (ab_lv !== 1'b0) begin errors++; $display("FAIL abort_lvalid: got %0b need 0", ab_lv); end
        vectors++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: pulses %0d need 0", done_cnt); end
        d = qdiff(obs_t, exp_t); vectors++;
        if (d != -1) begin errors++; $display("FAIL abort_tiles: idx %0d got %0d need %0d", d, qat(obs_t, d), qat(exp_t, d)); end
        build_expected(3, 2, 2, 500, 40, -1, 0, 0);
        run_layer(3, 2, 2, 500, 40, 2, -1, 0, 0, -1);
        d = qdiff(obs_t, exp_t); vectors++;
        if (d != -1) begin errors++; $display("FAIL after_abort_tiles: idx %0d got %0d need %0d", d, qat(obs_t, d), qat(exp_t, d)); end
        d = qdiff(obs_w, exp_w); vectors++;
        if (d != -1) begin errors++; $display("FAIL after_abort_waddr: idx %0d got %0d need %0d", d, qat(obs_w, d), qat(exp_w, d)); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL after_abort_done: pulses %0d need 1", done_cnt); end
    endtask

    task automatic test_async_reset();
        int bb = $urandom_range(0, 127);
        @(posedge clk); #1;
        grid_w = 3'd4; grid_h = 3'd4; num_groups = 7'd3; w_base = 11'd7; b_base = 7'(bb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        vectors++;
        if (int'(sram_raddr_bias) !== (bb + 1) % 128 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_loadb: baddr %0d busy %0b need %0d and 1", sram_raddr_bias, busy, (bb + 1) % 128);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (all_out !== 36'd0) begin errors++; $display("FAIL async_reset: outputs %h, need 0", all_out); end
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (all_out !== 36'd0) begin errors++; $display("FAIL post_reset_idle: outputs %h, need 0", all_out); end
    endtask

    task automatic test_ignore_start();
        int d;
        build_expected(3, 3, 2, 300, 20, -1, 0, 0);
        run_layer(3, 3, 2, 300, 20, 2, -1, 0, 0, 5);
        d = qdiff(obs_w, exp_w); vectors++;
        if (d != -1) begin errors++; $display("FAIL ignore_waddr: idx %0d got %0d need %0d", d, qat(obs_w, d), qat(exp_w, d)); end
        d = qdiff(obs_t, exp_t); vectors++;
        if (d != -1) begin errors++; $display("FAIL ignore_tiles: idx %0d got %0d need %0d", d, qat(obs_t, d), qat(exp_t, d)); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done: pulses %0d need 1", done_cnt); end
    endtask

    task automatic test_random();
        int d, gw, gh, ng, wb, bb;
        for (int n = 0; n < 4; n++) begin
            gw = $urandom_range(0, 7); gh = $urandom_range(0, 7); ng = $urandom_range(0, 6);
            wb = $urandom_range(0, 2047); bb = $urandom_range(0, 127);
            build_expected(gw, gh, ng, wb, bb, -1, 0, 0);
            run_layer(gw, gh, ng, wb, bb, 2, -1, 0, 0, -1);
            d = qdiff(obs_w, exp_w); vectors++;
            if (d != -1) begin errors++; $display("FAIL rand_waddr[%0d]: idx %0d got %0d need %0d", n, d, qat(obs_w, d), qat(exp_w, d)); end
            d = qdiff(obs_b, exp_b); vectors++;
            if (d != -1) begin errors++; $display("FAIL rand_baddr[%0d]: idx %0d got %0d need %0d", n, d, qat(obs_b, d), qat(exp_b, d)); end
            d = qdiff(obs_t, exp_t); vectors++;
            if (d != -1) begin errors++; $display("FAIL rand_tiles[%0d]: idx %0d got %0d need %0d", n, d, qat(obs_t, d), qat(exp_t, d)); end
            vectors++; if (hold_viol !== 0 || done_cnt !== 1) begin
                errors++; $display("FAIL rand_ctrl[%0d]: hold moves %0d done %0d, need 0 and 1", n, hold_viol, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_stall();
        test_wrap();
        test_abort();
        test_async_reset();
        test_ignore_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
